// File: rtl/rca_share_if.sv
// Request, response and shared-adder signals for rca_share_seq.
// slave is the sequencer side; master is the requesters/consumer/adder side.
interface rca_share_if #(parameter int NBYTES = 4);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [8*NBYTES-1:0]   req0_a;
    logic [8*NBYTES-1:0]   req0_b;
    logic                  req0_cin;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [8*NBYTES-1:0]   req1_a;
    logic [8*NBYTES-1:0]   req1_b;
    logic                  req1_cin;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [8*NBYTES-1:0]   rsp_sum;
    logic                  rsp_cout;
    logic [7:0]            add_x;
    logic [7:0]            add_y;
    logic                  add_cin;
    logic [7:0]            add_s;
    logic                  add_cout;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  rsp_ready, add_s, add_cout,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout,
        output add_x, add_y, add_cin
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output rsp_ready, add_s, add_cout,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
        input  add_x, add_y, add_cin
    );
endinterface

// File: rtl/rca_share_seq.sv
// Round-robin sequencer sharing one external 8-bit ripple-carry adder between
// two requesters; each NBYTES-wide add is fed LSB byte first with a registered carry.
//   state | meaning
//   IDLE  | arbitrate, latch operands of the granted requester
//   RUN   | one operand byte through the adder per cycle
//   DONE  | hold result on the response channel until accepted
module rca_share_seq #(
    parameter int NBYTES = 4
) (
    input  logic clk,
    input  logic rst,
    rca_share_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic            ptr;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    a_reg, b_reg, sum_reg;
    logic            id_reg;
    logic            cout_reg;

    logic            gnt0, gnt1;
    logic            last;
    logic            rsp_valid;
    logic [7:0]      x_byte, y_byte;
    logic            x_cin;

    assign last = (idx == IW'(NBYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            id_reg   <= 1'b0;
            cout_reg <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        a_reg  <= gnt1 ? bus.req1_a   : bus.req0_a;
                        b_reg  <= gnt1 ? bus.req1_b   : bus.req0_b;
                        carry  <= gnt1 ? bus.req1_cin : bus.req0_cin;
                        id_reg <= gnt1;
                        ptr    <= ~gnt1;
                        idx    <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (idx == IW'(i))
                            sum_reg[8*i +: 8] <= bus.add_s;
                    end
                    carry <= bus.add_cout;
                    idx   <= idx + 1'b1;
                    if (last)
                        cout_reg <= bus.add_cout;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rsp_valid = 1'b0;
        x_byte    = 8'h00;
        y_byte    = 8'h00;
        x_cin     = 1'b0;
        case (state)
            IDLE: begin
                gnt0 = bus.req0_valid & (~ptr | ~bus.req1_valid);
                gnt1 = bus.req1_valid & (ptr | ~bus.req0_valid);
                if (gnt0 || gnt1)
                    state_nxt = RUN;
            end
            RUN: begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx == IW'(i)) begin
                        x_byte = a_reg[8*i +: 8];
                        y_byte = b_reg[8*i +: 8];
                    end
                end
                x_cin = carry;
                if (last)
                    state_nxt = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_id     = id_reg;
    assign bus.rsp_sum    = sum_reg;
    assign bus.rsp_cout   = cout_reg;
    assign bus.add_x      = x_byte;
    assign bus.add_y      = y_byte;
    assign bus.add_cin    = x_cin;
endmodule
